// File: rtl/lagd_l1_stream_reader.sv
// L1 read initiator: issues req/gnt word reads over a range and returns the data
// as a valid/ready stream, with credits so memory responses are never stalled.
module lagd_l1_stream_reader #(
   parameter int unsigned AddrWidth      = 16,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned LenWidth       = 16,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [LenWidth-1:0]  num_words_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 last_o
);

   localparam int unsigned          CntW      = $clog2(MaxOutstanding + 1);
   localparam int unsigned          PtrW      = $clog2(MaxOutstanding);
   localparam logic [AddrWidth-1:0] Step      = AddrWidth'(DataWidth / 8);
   localparam logic [AddrWidth-1:0] AlignMask = ~(Step - AddrWidth'(1));
   localparam logic [CntW:0]        Credits   = (CntW + 1)'(MaxOutstanding);
   localparam logic [CntW-1:0]      CntOne    = CntW'(1);
   localparam logic [CntW-1:0]      CntFull   = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0]      LastSlot  = PtrW'(MaxOutstanding - 1);
   localparam logic [LenWidth:0]    LenOne    = (LenWidth + 1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   logic [LenWidth:0]    len_q, issued_q, popped_q;
   logic [CntW-1:0]      inflight_q, count_q;
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [DataWidth-1:0] fifo_q [MaxOutstanding];
   logic                 grant, push, pop, last_grant, last_pop, start_ok;

   // Credits: in-flight requests plus buffered words never exceed FIFO depth,
   // and the sum cannot rise without a grant, so a raised request stays raised.
   assign mem_req_o  = (state_q == ISSUE) &&
                       (({1'b0, inflight_q} + {1'b0, count_q}) < Credits);
   assign mem_addr_o = addr_q;
   assign mem_we_o   = 1'b0;
   assign grant      = mem_req_o & mem_gnt_i;
   assign push       = mem_rvalid_i && (inflight_q != '0);
   assign valid_o    = (count_q != '0);
   assign pop        = valid_o & ready_i;
   assign data_o     = fifo_q[rd_ptr_q];
   assign last_o     = valid_o && ((popped_q + LenOne) == len_q);
   assign last_grant = grant && ((issued_q + LenOne) == len_q);
   assign last_pop   = pop & last_o;
   assign start_ok   = (state_q == IDLE) && start_i;
   assign busy_o     = (state_q == ISSUE) || (state_q == DRAIN);
   assign done_o     = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_i) state_d = (num_words_i == '0) ? DONE : ISSUE;
         ISSUE: if (last_grant) state_d = DRAIN;
         DRAIN: if (last_pop) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
      end else begin
         if (start_ok) begin
            addr_q   <= base_addr_i & AlignMask;
            len_q    <= {1'b0, num_words_i};
            issued_q <= '0;
            popped_q <= '0;
         end else begin
            if (grant) begin
               addr_q   <= addr_q + Step;
               issued_q <= issued_q + LenOne;
            end
            if (pop) popped_q <= popped_q + LenOne;
         end

         if (grant && !push)      inflight_q <= inflight_q + CntOne;
         else if (!grant && push) inflight_q <= inflight_q - CntOne;

         if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
            wr_ptr_q         <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + PtrW'(1);

         if (push && !pop)      count_q <= count_q + CntOne;
         else if (pop && !push) count_q <= count_q - CntOne;
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push && !pop && (count_q == CntFull)));

endmodule

// File: tb/tb_lagd_l1_stream_reader.sv
// Randomized bench: a latency-randomized memory model feeds the reader; the
// observed request addresses and stream words are compared to the expected range.
module tb_lagd_l1_stream_reader;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] base_addr_i = '0;
   logic [15:0] num_words_i = '0;
   logic        busy_o, done_o, mem_req_o, mem_we_o, valid_o, last_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, ready_i = 1'b0;
   logic [15:0] mem_addr_o;
   logic [63:0] mem_rdata_i = '0, data_o;

   lagd_l1_stream_reader dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0, start_cyc = 0, done_cyc = 0, last_pop_cyc = 0, first_vcyc = -1;
   int gnt_pct = 100, rdy_pct = 100, min_dly = 1, max_dly = 1;
   int hold_idx = -1, hold_left = 0;
   int done_cnt = 0, valid_seen = 0, req_cycles = 0, unstable = 0, maxout = 0;
   bit start_pend = 0, stall_q = 0, stall_l = 0;
   logic [63:0] stall_d = '0;
   logic [15:0] salt = 16'h1111;
   logic [15:0] rq_addr[$];
   int          rq_due[$];
   logic [15:0] obs_addr[$];
   int          obs_gcyc[$];
   logic [63:0] obs_data[$];
   bit          obs_last[$];
   logic [15:0] hold_addrs[$];

   function automatic logic [63:0] mem_word(input logic [15:0] a);
      return {a ^ salt, ~a, a + 16'h1357, salt ^ 16'hC3C3};
   endfunction

   function automatic logic [15:0] exp_addr(input logic [15:0] base, input int i);
      return base + 16'(i * 8);
   endfunction

   // One clock of environment: memory model, stream sink, and observation capture.
   task automatic step();
      @(negedge clk);
      cyc++;
      start_i = start_pend;
      if (start_pend) start_cyc = cyc;
      start_pend = 0;
      ready_i   = (int'($urandom_range(99)) < rdy_pct);
      mem_gnt_i = (int'($urandom_range(99)) < gnt_pct);
      if (mem_req_o && hold_left > 0 && obs_addr.size() == hold_idx) begin
         mem_gnt_i = 1'b0;
         hold_left--;
         hold_addrs.push_back(mem_addr_o);
      end
      if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(rq_addr.pop_front());
         void'(rq_due.pop_front());
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = {$urandom, $urandom};
      end
      if (mem_req_o) begin
         req_cycles++;
         if (mem_gnt_i) begin
            obs_addr.push_back(mem_addr_o);
            obs_gcyc.push_back(cyc);
            rq_addr.push_back(mem_addr_o);
            rq_due.push_back(cyc + int'($urandom_range(max_dly, min_dly)));
            if (obs_addr.size() - obs_data.size() > maxout) maxout = obs_addr.size() - obs_data.size();
         end
      end
      if (stall_q && valid_o && (data_o !== stall_d || last_o !== stall_l)) unstable++;
      stall_q = valid_o && !ready_i;
      stall_d = data_o;
      stall_l = last_o;
      if (valid_o) begin
         valid_seen++;
         if (first_vcyc < 0) first_vcyc = cyc;
         if (ready_i) begin
            obs_data.push_back(data_o);
            obs_last.push_back(last_o);
            last_pop_cyc = cyc;
         end
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic clear_obs();
      obs_addr.delete(); obs_gcyc.delete(); obs_data.delete(); obs_last.delete();
      hold_addrs.delete();
      done_cnt = 0; valid_seen = 0; req_cycles = 0; unstable = 0; maxout = 0;
      first_vcyc = -1;
   endtask

   task automatic kick(input logic [15:0] base, input logic [15:0] len);
      clear_obs();
      base_addr_i = base;
      num_words_i = len;
      start_pend  = 1;
      step();
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      if (done_cnt == 0) begin
         total++; bad++;
         $display("FAIL %s_timeout got=no done_o exp=done_o within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      gnt_pct = 0; rdy_pct = 0;
      step(); step();
      total++;
      if ({busy_o, done_o, mem_req_o, mem_we_o, valid_o, last_o, mem_addr_o, data_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%b addr=%h data=%h exp=all zero",
                  busy_o, done_o, mem_req_o, mem_we_o, valid_o, last_o, mem_addr_o, data_o);
      end
      rst_ni = 1'b1;
      step();
      total++;
      if ({busy_o, mem_req_o, valid_o} !== 3'b000) begin
         bad++; $display("FAIL reset_idle got=%b exp=000", {busy_o, mem_req_o, valid_o});
      end
   endtask

   task automatic test_basic();
      gnt_pct = 100; rdy_pct = 100; min_dly = 1; max_dly = 1; salt = 16'h2222;
      kick(16'h0100, 16'd4);
      wait_done(40, "basic");
      total++;
      if (obs_addr.size() != 4 || obs_data.size() != 4) begin
         bad++; $display("FAIL basic_count got=%0d/%0d exp=4/4", obs_addr.size(), obs_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_addr[i] !== exp_addr(16'h0100, i) || obs_gcyc[i] != start_cyc + 1 + i) begin
               bad++; $display("FAIL basic_req%0d got=%h@%0d exp=%h@%0d", i, obs_addr[i],
                               obs_gcyc[i], exp_addr(16'h0100, i), start_cyc + 1 + i);
            end
            total++;
            if (obs_data[i] !== mem_word(exp_addr(16'h0100, i)) || obs_last[i] != (i == 3)) begin
               bad++; $display("FAIL basic_word%0d got=%h last=%0d exp=%h last=%0d", i, obs_data[i],
                               obs_last[i], mem_word(exp_addr(16'h0100, i)), i == 3);
            end
         end
      end
      total++;
      if (first_vcyc != start_cyc + 3) begin
         bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_vcyc - start_cyc, 3);
      end
      total++;
      if (done_cyc != last_pop_cyc + 1 || busy_o !== 1'b0) begin
         bad++; $display("FAIL basic_done got=%0d busy=%b exp=%0d busy=0", done_cyc, busy_o, last_pop_cyc + 1);
      end
   endtask

   task automatic test_zero_len();
      kick(16'h0500, 16'd0);
      wait_done(10, "zero");
      repeat (4) step();
      total++;
      if (req_cycles != 0 || valid_seen != 0 || done_cnt != 1) begin
         bad++; $display("FAIL zero_len got=req%0d valid%0d done%0d exp=0/0/1", req_cycles, valid_seen, done_cnt);
      end
      total++;
      if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
         bad++; $display("FAIL zero_done_delay got=%0d exp=1..2", done_cyc - start_cyc);
      end
   endtask

   task automatic test_credit();
      gnt_pct = 100; rdy_pct = 0; salt = 16'h3333;
      kick(16'h0400, 16'd8);
      repeat (12) step();
      total++;
      if (obs_addr.size() != 4 || mem_req_o !== 1'b0) begin
         bad++; $display("FAIL credit_stall got=%0d req=%b exp=4 req=0", obs_addr.size(), mem_req_o);
      end
      rdy_pct = 100;
      wait_done(60, "credit");
      total++;
      if (obs_addr.size() != 8 || obs_data.size() != 8) begin
         bad++; $display("FAIL credit_count got=%0d/%0d exp=8/8", obs_addr.size(), obs_data.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (obs_data[i] !== mem_word(exp_addr(16'h0400, i)) || obs_last[i] != (i == 7)) begin
               bad++; $display("FAIL credit_word%0d got=%h exp=%h", i, obs_data[i], mem_word(exp_addr(16'h0400, i)));
            end
         end
      end
   endtask

   task automatic test_gnt_stall();
      gnt_pct = 100; rdy_pct = 100; salt = 16'h4444;
      hold_idx = 1; hold_left = 3;
      kick(16'h0100, 16'd4);
      wait_done(40, "gntstall");
      hold_idx = -1;
      total++;
      if (hold_addrs.size() != 3 || obs_addr.size() != 4) begin
         bad++; $display("FAIL gnt_stall_count got=%0d/%0d exp=3/4", hold_addrs.size(), obs_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (hold_addrs[i] !== 16'h0108) begin
               bad++; $display("FAIL gnt_stall_addr%0d got=%h exp=0108", i, hold_addrs[i]);
            end
         end
         total++;
         if (obs_addr[1] !== 16'h0108 || obs_data.size() != 4) begin
            bad++; $display("FAIL gnt_stall_req got=%h exp=0108", obs_addr[1]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] base;
      int ok;
      base = 16'($urandom) & 16'hFFF8;
      salt = 16'($urandom);
      gnt_pct = 60; rdy_pct = 60; min_dly = 1; max_dly = 4;
      kick(base, 16'd100);
      wait_done(3000, "random");
      total++;
      if (obs_addr.size() != 100 || obs_data.size() != 100) begin
         bad++; $display("FAIL random_count got=%0d/%0d exp=100/100", obs_addr.size(), obs_data.size());
      end else begin
         ok = 1;
         for (int i = 0; i < 100; i++)
            if (obs_addr[i] !== exp_addr(base, i) || obs_data[i] !== mem_word(exp_addr(base, i)) ||
                obs_last[i] != (i == 99)) begin
               if (ok) $display("FAIL random_word%0d got=%h/%h exp=%h/%h", i, obs_addr[i], obs_data[i],
                                exp_addr(base, i), mem_word(exp_addr(base, i)));
               ok = 0;
            end
         total++;
         if (!ok) bad++;
      end
      total++;
      if (unstable != 0 || maxout > 4 || done_cyc != last_pop_cyc + 1) begin
         bad++; $display("FAIL random_proto got=unstable%0d maxout%0d done%0d exp=0/<=4/%0d",
                         unstable, maxout, done_cyc, last_pop_cyc + 1);
      end
      gnt_pct = 100; rdy_pct = 100; min_dly = 1; max_dly = 1;
   endtask

   task automatic test_wrap();
      salt = 16'h5555;
      kick(16'hFFF8, 16'd2);
      wait_done(30, "wrap");
      total++;
      if (obs_addr.size() != 2 || obs_data.size() != 2) begin
         bad++; $display("FAIL wrap_count got=%0d/%0d exp=2/2", obs_addr.size(), obs_data.size());
      end else begin
         total++;
         if (obs_addr[0] !== 16'hFFF8 || obs_addr[1] !== 16'h0000 ||
             obs_data[1] !== mem_word(16'h0000) || obs_last[1] != 1'b1) begin
            bad++; $display("FAIL wrap_addr got=%h,%h exp=fff8,0000", obs_addr[0], obs_addr[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      salt = 16'h6666;
      gnt_pct = 100; rdy_pct = 0; min_dly = 3; max_dly = 3;
      kick(16'h0200, 16'd8);
      while (rq_addr.size() < 2 && n < 10) begin step(); n++; end
      gnt_pct = 0;
      step();
      clear_obs();
      rst_ni = 1'b0;
      #1;
      total++;
      if ({busy_o, done_o, mem_req_o, valid_o, last_o, mem_addr_o, data_o} !== '0) begin
         bad++; $display("FAIL rstmid_outputs got=%b/%b/%b/%b/%b addr=%h data=%h exp=all zero",
                         busy_o, done_o, mem_req_o, valid_o, last_o, mem_addr_o, data_o);
      end
      step();
      rst_ni = 1'b1;
      rdy_pct = 100;
      repeat (6) step();
      total++;
      if (valid_seen != 0 || done_cnt != 0 || rq_addr.size() != 0) begin
         bad++; $display("FAIL rstmid_drop got=valid%0d done%0d pend%0d exp=0/0/0", valid_seen, done_cnt, rq_addr.size());
      end
      salt = 16'h7777;
      gnt_pct = 100; min_dly = 1; max_dly = 1;
      kick(16'h0300, 16'd1);
      wait_done(30, "rstmid");
      total++;
      if (obs_data.size() != 1 || obs_addr.size() != 1) begin
         bad++; $display("FAIL rstmid_count got=%0d/%0d exp=1/1", obs_addr.size(), obs_data.size());
      end else begin
         total++;
         if (obs_data[0] !== mem_word(16'h0300) || obs_last[0] != 1'b1) begin
            bad++; $display("FAIL rstmid_word got=%h last=%0d exp=%h last=1", obs_data[0], obs_last[0], mem_word(16'h0300));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_credit();
      test_gnt_stall();
      test_random();
      test_wrap();
      test_reset_mid();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
